// File: rtl/common.sv
// common: shared types for the magic button front end
package common;
  typedef enum logic [1:0] {BTN_DISARMED, BTN_IDLE, BTN_PRESSED, BTN_LONG} btn_state_t;
endpackage

// File: rtl/debounce.sv
// debounce: 2-flop synchroniser on an active-low pin plus a tick-based stability filter
module debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk28,
  input  logic rst,
  input  logic tick,
  input  logic pin_n,
  output logic raw,
  output logic level
);
  localparam int W = $clog2(DEBOUNCE_MS + 1);
  logic [1:0] sync;
  logic [W-1:0] cnt;
  always_ff @(posedge clk28) sync <= {sync[0], pin_n};
  assign raw = !sync[1];
  // level flips on the tick that completes DEBOUNCE_MS ticks of continuous disagreement
  always_ff @(posedge clk28) begin
    if (rst) begin
      level <= 1'b0;
      cnt <= '0;
    end else if (raw == level) begin
      cnt <= '0;
    end else if (tick) begin
      level <= (cnt == W'(DEBOUNCE_MS - 1)) ? raw : level;
      cnt <= (cnt == W'(DEBOUNCE_MS - 1)) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/magic_button_ctl.sv
// magic_button_ctl: debounced magic button, short/long press classification and held magic/pause requests
module magic_button_ctl import common::*; #(
  parameter int TICK_DIV    = 28000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic clk28,
  input  logic rst,
  input  logic btn_n,
  input  logic kbd_magic,
  input  logic kbd_pause,
  input  logic n_int,
  input  logic n_int_next,
  output logic magic_button,
  output logic pause_button,
  output logic reboot_req,
  output logic btn_down
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int HW = $clog2(LONG_MS + 1);
  btn_state_t state;
  logic [PW-1:0] presc;
  logic [HW-1:0] hold;
  logic tick, raw, kbd_magic_q, kbd_pause_q, frame_edge, magic_set, pause_set;
  assign tick = presc == PW'(TICK_DIV - 1);
  assign frame_edge = n_int && !n_int_next;
  assign magic_set = (state == BTN_PRESSED && !btn_down) || (kbd_magic && !kbd_magic_q);
  assign pause_set = kbd_pause && !kbd_pause_q;
  debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_debounce (
    .clk28,
    .rst,
    .tick,
    .pin_n(btn_n),
    .raw,
    .level(btn_down)
  );
  always_ff @(posedge clk28) presc <= (rst || tick) ? '0 : presc + 1'b1;
  // DISARMED also waits for the raw pin so a button held through reset never fires
  always_ff @(posedge clk28) begin
    if (rst) begin
      state <= BTN_DISARMED;
      hold <= '0;
      reboot_req <= 1'b0;
    end else begin
      reboot_req <= 1'b0;
      case (state)
        BTN_DISARMED: state <= (!btn_down && !raw) ? BTN_IDLE : BTN_DISARMED;
        BTN_IDLE: begin
          state <= btn_down ? BTN_PRESSED : BTN_IDLE;
          hold <= '0;
        end
        BTN_PRESSED:
          if (!btn_down) state <= BTN_IDLE;
          else if (tick) begin
            hold <= hold + 1'b1;
            reboot_req <= hold == HW'(LONG_MS - 1);
            state <= (hold == HW'(LONG_MS - 1)) ? BTN_LONG : BTN_PRESSED;
          end
        BTN_LONG: state <= btn_down ? BTN_LONG : BTN_IDLE;
      endcase
    end
  end
  // edge detectors track the key level during reset so a key held across release is not an edge
  always_ff @(posedge clk28) begin
    kbd_magic_q <= kbd_magic;
    kbd_pause_q <= kbd_pause;
    magic_button <= !rst && (magic_set || (magic_button && !frame_edge));
    pause_button <= !rst && (pause_set || (pause_button && !frame_edge));
  end
endmodule

// File: tb/tb_magic_button_ctl.sv
// tb_magic_button_ctl: directed and randomized checks against a behavioural model of the button front end
module tb_magic_button_ctl;
  localparam int TD = 10, DB = 2, LM = 8;
  logic clk28 = 0, rst = 1, btn_n = 1, kbd_magic = 0, kbd_pause = 0, n_int = 0, n_int_next = 0;
  logic magic_button, pause_button, reboot_req, btn_down;
  int checks = 0, errors = 0, rb_cnt = 0;
  bit chk_en = 0;
  bit ms1 = 1, ms2 = 1, m_down, m_magic, m_pause, m_reboot, km, kp;
  bit armed, pressing, is_long;
  int mcyc, dcnt, hold;

  magic_button_ctl #(.TICK_DIV(TD), .DEBOUNCE_MS(DB), .LONG_MS(LM)) dut (
    .clk28(clk28), .rst(rst), .btn_n(btn_n), .kbd_magic(kbd_magic), .kbd_pause(kbd_pause),
    .n_int(n_int), .n_int_next(n_int_next), .magic_button(magic_button),
    .pause_button(pause_button), .reboot_req(reboot_req), .btn_down(btn_down)
  );

  always #5 clk28 = ~clk28;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s got %0d want %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk28);
    #1;
  endtask

  task automatic wait_down(input logic lvl, output int n);
    n = 0;
    while (btn_down !== lvl && n < 300) begin
      @(negedge clk28);
      n++;
    end
    chk_rng("wait_btn_down", n, 0, 299);
  endtask

  // Reference: press lifecycle from the rules (arm on release, time a press in ticks, short vs long)
  task automatic model_step();
    bit raw_o, down_o, tk, fe, sm, sp, rb;
    raw_o = !ms2;
    down_o = m_down;
    tk = (mcyc == TD - 1);
    fe = n_int && !n_int_next;
    sm = kbd_magic && !km;
    sp = kbd_pause && !kp;
    rb = 0;
    if (rst) begin
      mcyc = 0; m_down = 0; dcnt = 0; armed = 0; pressing = 0; is_long = 0; hold = 0;
      m_magic = 0; m_pause = 0;
    end else begin
      mcyc = (mcyc + 1) % TD;
      dcnt = (raw_o == down_o) ? 0 : dcnt + int'(tk);
      if (dcnt == DB) begin
        m_down = raw_o;
        dcnt = 0;
      end
      if (!armed) armed = !down_o && !raw_o;
      else if (!pressing) begin
        pressing = down_o;
        hold = 0;
        is_long = 0;
      end else if (!down_o) begin
        sm = sm || !is_long;
        pressing = 0;
      end else if (tk && !is_long) begin
        hold++;
        if (hold == LM) begin
          rb = 1;
          is_long = 1;
        end
      end
      m_magic = sm || (m_magic && !fe);
      m_pause = sp || (m_pause && !fe);
    end
    m_reboot = rb;
    km = kbd_magic;
    kp = kbd_pause;
    ms2 = ms1;
    ms1 = btn_n;
  endtask

  initial forever begin
    @(posedge clk28);
    model_step();
  end

  always @(negedge clk28) begin
    if (reboot_req) rb_cnt <= rb_cnt + 1;
    if (chk_en) begin
      chk("m_btn_down", int'(btn_down), int'(m_down));
      chk("m_magic", int'(magic_button), int'(m_magic));
      chk("m_pause", int'(pause_button), int'(m_pause));
      chk("m_reboot", int'(reboot_req), int'(m_reboot));
    end
  end

  initial begin
    int n, m, r0, left;
    step(5);
    @(negedge clk28);
    chk("rst_magic", int'(magic_button), 0);
    chk("rst_pause", int'(pause_button), 0);
    chk("rst_reboot", int'(reboot_req), 0);
    chk("rst_down", int'(btn_down), 0);
    chk_en = 1;
    step(1);
    rst = 0;
    step(10);
    // short press
    btn_n = 0;
    wait_down(1, n);
    chk_rng("short_latency", n, 12, 23);
    step(50 - n);
    btn_n = 1;
    wait_down(0, n);
    chk("short_magic_pre", int'(magic_button), 0);
    @(negedge clk28);
    chk("short_magic", int'(magic_button), 1);
    chk("short_noreboot", rb_cnt, 0);
    // consumption
    step(1);
    n_int = 1; n_int_next = 0;
    @(negedge clk28);
    chk("consume_hold", int'(magic_button), 1);
    step(1);
    n_int = 0;
    @(negedge clk28);
    chk("consume_clear", int'(magic_button), 0);
    // long press
    step(1);
    r0 = rb_cnt;
    btn_n = 0;
    wait_down(1, n);
    m = 0;
    while (!reboot_req && m < 200) begin
      @(negedge clk28);
      m++;
    end
    chk_rng("long_latency", m, 75, 85);
    step(150 - n - m);
    btn_n = 1;
    wait_down(0, n);
    step(5);
    chk("long_one_reboot", rb_cnt - r0, 1);
    chk("long_nomagic", int'(magic_button), 0);
    // bounce
    for (int i = 0; i < 20; i++) begin
      btn_n = ~btn_n;
      step(5);
      chk("bounce_down", int'(btn_down), 0);
    end
    step(30);
    chk("bounce_nomagic", int'(magic_button), 0);
    chk("bounce_noreboot", rb_cnt - r0, 1);
    // keyboard magic coincident with a frame edge
    kbd_magic = 1; n_int = 1; n_int_next = 0;
    @(negedge clk28);
    chk("coinc_pre", int'(magic_button), 0);
    step(1);
    n_int = 0;
    @(negedge clk28);
    chk("coinc_set", int'(magic_button), 1);
    step(3);
    chk("coinc_survive", int'(magic_button), 1);
    n_int = 1;
    step(1);
    n_int = 0; kbd_magic = 0;
    @(negedge clk28);
    chk("coinc_consumed", int'(magic_button), 0);
    // keyboard pause
    step(1);
    kbd_pause = 1;
    step(1);
    @(negedge clk28);
    chk("pause_set", int'(pause_button), 1);
    chk("pause_magic_clear", int'(magic_button), 0);
    step(1);
    n_int = 1;
    step(1);
    n_int = 0;
    @(negedge clk28);
    chk("pause_consumed", int'(pause_button), 0);
    step(1);
    rst = 1;
    step(3);
    rst = 0;
    step(5);
    chk("pause_across_rst", int'(pause_button), 0);
    kbd_pause = 0;
    // reset mid-press
    btn_n = 0;
    wait_down(1, n);
    step(1);
    rst = 1;
    step(1);
    rst = 0;
    @(negedge clk28);
    chk("midrst_down", int'(btn_down), 0);
    chk("midrst_magic", int'(magic_button), 0);
    r0 = rb_cnt;
    step(150);
    chk("midrst_noreboot", rb_cnt - r0, 0);
    chk("midrst_nomagic", int'(magic_button), 0);
    chk("midrst_held_down", int'(btn_down), 1);
    btn_n = 1;
    wait_down(0, n);
    step(20);
    chk("midrst_release_nomagic", int'(magic_button), 0);
    btn_n = 0;
    step(50);
    btn_n = 1;
    n = 0;
    while (!magic_button && n < 100) begin
      @(negedge clk28);
      n++;
    end
    chk("midrst_repress_magic", int'(magic_button), 1);
    // randomized traffic
    left = 0;
    repeat (3000) begin
      if (left == 0) begin
        btn_n = ~btn_n;
        left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(20, 160);
      end
      left--;
      if ($urandom_range(0, 7) == 0) kbd_magic = ~kbd_magic;
      if ($urandom_range(0, 7) == 0) kbd_pause = ~kbd_pause;
      n_int = $urandom_range(0, 3) != 0;
      n_int_next = $urandom_range(0, 3) == 0;
      rst = $urandom_range(0, 999) == 0;
      step(1);
    end
    rst = 0;
    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
